// File: rtl/conv_share_arbiter.sv
// Shares one soc/eoc A/D converter among four 4-phase requesters.
// Round-robin grant, one conversion per grant, watchdog abort on a hung converter.
module conv_share_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic [3:0] soc_in,
    output logic [3:0] eoc_out,
    output logic [7:0] x_out,
    output logic       err_out,
    output logic [1:0] grant,
    output logic       busy,
    output logic       soc,
    input  logic       eoc,
    input  logic [7:0] x
);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StDeliver} state_e;

    // Watchdog fires on the edge where the counter shows the last allowed cycle.
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] eoc_out_q, eoc_out_d;
    logic [7:0] x_out_q, x_out_d;
    logic       err_out_q, err_out_d;
    logic [1:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       soc_q, soc_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       timeout_hit;
    logic [3:0] grant_oh;

    assign timeout_hit = (cnt_q == TimeoutCnt);
    assign grant_oh    = 4'b0001 << grant_q;

    // Round-robin pick: first requester scanning last+1, last+2, ... mod 4.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_q;
        cand       = last_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!pick_valid && soc_in[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q   <= StIdle;
            eoc_out_q <= 4'b0000;
            x_out_q   <= 8'h00;
            err_out_q <= 1'b0;
            grant_q   <= 2'd0;
            busy_q    <= 1'b0;
            soc_q     <= 1'b0;
            cnt_q     <= 8'd0;
            last_q    <= 2'd3;
        end else begin
            state_q   <= state_d;
            eoc_out_q <= eoc_out_d;
            x_out_q   <= x_out_d;
            err_out_q <= err_out_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            soc_q     <= soc_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    // Next-state: normal handshake exit takes priority over the watchdog.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // eoc low here means the converter is still busy after an abort.
                if (pick_valid && eoc) state_d = StStart;
            end
            StStart: begin
                if (!eoc)             state_d = StWait;
                else if (timeout_hit) state_d = StDeliver;
            end
            StWait: begin
                if (eoc || timeout_hit) state_d = StDeliver;
            end
            StDeliver: begin
                if (!soc_in[grant_q]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, counter and round-robin pointer.
    always_comb begin
        eoc_out_d = eoc_out_q;
        x_out_d   = x_out_q;
        err_out_d = err_out_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        soc_d     = soc_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid && eoc) begin
                    grant_d = pick_idx;
                    soc_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                end
            end
            StStart: begin
                cnt_d = cnt_q + 8'd1;
                if (!eoc) begin
                    soc_d = 1'b0;
                end else if (timeout_hit) begin
                    soc_d     = 1'b0;
                    x_out_d   = 8'hFF;
                    err_out_d = 1'b1;
                    eoc_out_d = grant_oh;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 8'd1;
                if (eoc) begin
                    x_out_d   = x;
                    err_out_d = 1'b0;
                    eoc_out_d = grant_oh;
                end else if (timeout_hit) begin
                    soc_d     = 1'b0;
                    x_out_d   = 8'hFF;
                    err_out_d = 1'b1;
                    eoc_out_d = grant_oh;
                end
            end
            StDeliver: begin
                // x_out/err_out deliberately held until the next capture.
                if (!soc_in[grant_q]) begin
                    eoc_out_d = 4'b0000;
                    last_d    = grant_q;
                    busy_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign eoc_out = eoc_out_q;
    assign x_out   = x_out_q;
    assign err_out = err_out_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign soc     = soc_q;

endmodule

// File: tb/tb_conv_share_arbiter.sv
// Directed bench for conv_share_arbiter with a small converter model (TIMEOUT=8).
module tb_conv_share_arbiter;

    logic       clock = 1'b0;
    logic       reset_ = 1'b1;
    logic [3:0] soc_in = 4'b0000;
    logic [3:0] eoc_out;
    logic [7:0] x_out;
    logic       err_out;
    logic [1:0] grant;
    logic       busy;
    logic       soc;
    logic       eoc = 1'b1;
    logic [7:0] x = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    // Converter model controls: mode 0 responsive, 1 dead (eoc stuck 1), 2 stuck low.
    int         conv_mode  = 0;
    int         conv_lat   = 1;
    int         conv_cnt   = 0;
    logic       conv_reset = 1'b0;
    logic       add_grant  = 1'b0;
    logic [7:0] data_base  = 8'h00;

    conv_share_arbiter #(.TIMEOUT(8)) dut (
        .clock   (clock),
        .reset_  (reset_),
        .soc_in  (soc_in),
        .eoc_out (eoc_out),
        .x_out   (x_out),
        .err_out (err_out),
        .grant   (grant),
        .busy    (busy),
        .soc     (soc),
        .eoc     (eoc),
        .x       (x)
    );

    always #5 clock = ~clock;

    // Converter model acts on the falling edge, away from the DUT's active edge.
    always @(negedge clock) begin
        if (conv_reset) begin
            eoc      <= 1'b1;
            conv_cnt <= 0;
        end else if (conv_mode == 1) begin
            eoc <= 1'b1;
        end else if (soc && eoc) begin
            eoc      <= 1'b0;
            conv_cnt <= (conv_mode == 2) ? 0 : conv_lat;
        end else if (!eoc && conv_mode == 0) begin
            if (conv_cnt > 1) begin
                conv_cnt <= conv_cnt - 1;
            end else begin
                conv_cnt <= 0;
                eoc      <= 1'b1;
                x        <= add_grant ? data_base + {6'b0, grant} : data_base;
            end
        end
    end

    task automatic wait_eoc(output int cycles);
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock); #1;
            cycles++;
            if (eoc_out != 4'b0000) break;
        end
    endtask

    task automatic test_reset();
        reset_ = 1'b0; soc_in = 4'b0000; conv_reset = 1'b1; conv_mode = 0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (soc !== 1'b0) begin n_fail++; $display("FAIL reset_soc got %0b want 0", soc); end
        n_checks++; if (eoc_out !== 4'b0000) begin n_fail++; $display("FAIL reset_eoc_out got %b want 0000", eoc_out); end
        n_checks++; if (x_out !== 8'h00) begin n_fail++; $display("FAIL reset_x_out got %h want 00", x_out); end
        n_checks++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", err_out); end
        n_checks++; if (grant !== 2'd0) begin n_fail++; $display("FAIL reset_grant got %0d want 0", grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        conv_reset = 1'b0;
        reset_ = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_single();
        int cyc;
        conv_mode = 0; conv_lat = 3; add_grant = 1'b0; data_base = 8'hA5;
        soc_in = 4'b0100;
        @(posedge clock); #1;
        n_checks++; if (soc !== 1'b1) begin n_fail++; $display("FAIL single_soc got %0b want 1", soc); end
        n_checks++; if (grant !== 2'd2) begin n_fail++; $display("FAIL single_grant got %0d want 2", grant); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %0b want 1", busy); end
        wait_eoc(cyc);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL single_latency got %0d want 4", cyc); end
        n_checks++; if (eoc_out !== 4'b0100) begin n_fail++; $display("FAIL single_eoc_out got %b want 0100", eoc_out); end
        n_checks++; if (x_out !== 8'hA5) begin n_fail++; $display("FAIL single_x got %h want a5", x_out); end
        n_checks++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL single_err got %0b want 0", err_out); end
        soc_in = 4'b0000;
        @(posedge clock); #1;
        n_checks++; if (eoc_out !== 4'b0000) begin n_fail++; $display("FAIL single_clear got %b want 0000", eoc_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int         order[5] = '{0, 1, 2, 3, 0};
        int         cyc;
        logic [3:0] exp_oh;
        logic [7:0] exp_x;
        test_reset();
        conv_lat = 1; add_grant = 1'b1; data_base = 8'h10;
        soc_in = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_oh = 4'b0001 << order[i];
            exp_x  = 8'(8'h10 + order[i]);
            wait_eoc(cyc);
            n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL rr_latency[%0d] got %0d want 3", i, cyc); end
            n_checks++; if (eoc_out !== exp_oh) begin n_fail++; $display("FAIL rr_eoc_out[%0d] got %b want %b", i, eoc_out, exp_oh); end
            n_checks++; if (grant !== 2'(order[i])) begin n_fail++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, grant, order[i]); end
            n_checks++; if (x_out !== exp_x) begin n_fail++; $display("FAIL rr_x[%0d] got %h want %h", i, x_out, exp_x); end
            if (i == 4) soc_in = 4'b0000;
            else        soc_in[order[i]] = 1'b0;
            @(posedge clock); #1;
            n_checks++; if (eoc_out !== 4'b0000) begin n_fail++; $display("FAIL rr_clear[%0d] got %b want 0000", i, eoc_out); end
            if (i != 4) soc_in[order[i]] = 1'b1;
        end
    endtask

    task automatic test_fairness();
        int cyc;
        soc_in = 4'b0100;
        wait_eoc(cyc);
        n_checks++; if (grant !== 2'd2) begin n_fail++; $display("FAIL fair_first got %0d want 2", grant); end
        soc_in = 4'b0000;
        @(posedge clock); #1;
        soc_in = 4'b0101;
        wait_eoc(cyc);
        n_checks++; if (grant !== 2'd0) begin n_fail++; $display("FAIL fair_grant0 got %0d want 0", grant); end
        n_checks++; if (x_out !== 8'h10) begin n_fail++; $display("FAIL fair_x0 got %h want 10", x_out); end
        soc_in = 4'b0100;
        @(posedge clock); #1;
        wait_eoc(cyc);
        n_checks++; if (grant !== 2'd2) begin n_fail++; $display("FAIL fair_grant2 got %0d want 2", grant); end
        n_checks++; if (x_out !== 8'h12) begin n_fail++; $display("FAIL fair_x2 got %h want 12", x_out); end
        soc_in = 4'b0000;
        @(posedge clock); #1;
    endtask

    task automatic test_timeout_start();
        int hi = 0;
        conv_mode = 1;
        soc_in = 4'b0010;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (soc === 1'b1) hi++;
            else if (hi > 0) break;
        end
        n_checks++; if (hi !== 8) begin n_fail++; $display("FAIL to_start_soc_cycles got %0d want 8", hi); end
        n_checks++; if (eoc_out !== 4'b0010) begin n_fail++; $display("FAIL to_start_eoc_out got %b want 0010", eoc_out); end
        n_checks++; if (x_out !== 8'hFF) begin n_fail++; $display("FAIL to_start_x got %h want ff", x_out); end
        n_checks++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL to_start_err got %0b want 1", err_out); end
        soc_in = 4'b0000;
        @(posedge clock); #1;
        n_checks++; if (eoc_out !== 4'b0000) begin n_fail++; $display("FAIL to_start_clear got %b want 0000", eoc_out); end
        n_checks++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL to_start_err_hold got %0b want 1", err_out); end
    endtask

    task automatic test_timeout_wait();
        int cyc;
        conv_mode = 2;
        soc_in = 4'b1000;
        @(posedge clock); #1;
        n_checks++; if (grant !== 2'd3) begin n_fail++; $display("FAIL to_wait_grant got %0d want 3", grant); end
        wait_eoc(cyc);
        n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL to_wait_cycles got %0d want 8", cyc); end
        n_checks++; if (eoc_out !== 4'b1000) begin n_fail++; $display("FAIL to_wait_eoc_out got %b want 1000", eoc_out); end
        n_checks++; if (x_out !== 8'hFF) begin n_fail++; $display("FAIL to_wait_x got %h want ff", x_out); end
        n_checks++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL to_wait_err got %0b want 1", err_out); end
        soc_in = 4'b0000;
        @(posedge clock); #1;
        // Converter still holds eoc low: a new request must not be granted.
        soc_in = 4'b0001;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (soc !== 1'b0) begin n_fail++; $display("FAIL to_wait_block_soc got %0b want 0", soc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_wait_block_busy got %0b want 0", busy); end
        conv_mode = 0; conv_lat = 1;
        wait_eoc(cyc);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL to_wait_resume_cycles got %0d want 3", cyc); end
        n_checks++; if (eoc_out !== 4'b0001) begin n_fail++; $display("FAIL to_wait_resume_eoc got %b want 0001", eoc_out); end
        n_checks++; if (x_out !== 8'h10) begin n_fail++; $display("FAIL to_wait_resume_x got %h want 10", x_out); end
        n_checks++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL to_wait_resume_err got %0b want 0", err_out); end
        soc_in = 4'b0000;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_wait();
        int cyc;
        conv_mode = 0; conv_lat = 20;
        soc_in = 4'b1111;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_busy got %0b want 1", busy); end
        reset_ = 1'b0;
        #1;
        n_checks++; if (soc !== 1'b0) begin n_fail++; $display("FAIL rst_mid_soc got %0b want 0", soc); end
        n_checks++; if (eoc_out !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_eoc_out got %b want 0000", eoc_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
        n_checks++; if (grant !== 2'd0) begin n_fail++; $display("FAIL rst_mid_grant got %0d want 0", grant); end
        conv_reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        conv_reset = 1'b0; conv_lat = 1;
        reset_ = 1'b1;
        wait_eoc(cyc);
        n_checks++; if (eoc_out !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_winner got %b want 0001", eoc_out); end
        n_checks++; if (grant !== 2'd0) begin n_fail++; $display("FAIL rst_mid_winner_grant got %0d want 0", grant); end
        soc_in = 4'b0000;
        @(posedge clock); #1;
    endtask

    initial begin
        #1 reset_ = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_timeout_start();
        test_timeout_wait();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_share_arbiter.md
Name: conv_share_arbiter

Overview:
- Shares one A/D converter (soc/eoc handshake, 8-bit data x) among 4 requesters, each with its own soc/eoc handshake.
- Round-robin arbitration, one conversion per grant. Captured byte is returned only to the granted requester.
- A watchdog aborts conversions that hang. The arbiter sits between the converter and the byte-processing consumers that each used to drive it directly.

Parameters:
TIMEOUT, 64, max cycles spent in START+WAIT before abort (2..255; counter 8 bits)

Ports:
clock  in  1  system clock, all state updates on posedge
reset_  in  1  asynchronous active-low reset
soc_in  in  4  per-requester start-of-conversion request, bit k = requester k
eoc_out  out  4  per-requester end-of-conversion / data-valid, bit k = requester k
x_out  out  8  returned byte, stable while any eoc_out bit is 1
err_out  out  1  1 = x_out is invalid (timeout), valid alongside eoc_out
grant  out  2  index of requester currently or last served
busy  out  1  1 whenever state != IDLE
soc  out  1  start-of-conversion to converter
eoc  in  1  converter end-of-conversion (idles at 1)
x  in  8  converter data, valid while eoc=1 after a conversion

Behaviour:
- Reset (reset_=0, async): soc=0, eoc_out=0, x_out=0, err_out=0, grant=0, busy=0, state=IDLE, CNT=0, LAST=3 (requester 0 has top priority after reset). Reset mid-conversion drops soc immediately; no data is delivered.
- All outputs are registered and change only on posedge clock (or on reset).
- Requester protocol (4-phase): requester raises soc_in[k] and holds it. Arbiter raises eoc_out[k] with x_out/err_out valid. Requester lowers soc_in[k]. Arbiter lowers eoc_out[k].
- Converter protocol: soc=1 until eoc=0 (conversion started). Then soc=0. Wait eoc=1, then sample x.
- IDLE: when any soc_in bit is 1 AND eoc=1, pick the first requesting index scanning LAST+1, LAST+2, ... mod 4.
  - On that edge: grant<=k, soc<=1, busy<=1, CNT<=0, ->START.
  - If eoc=0 in IDLE (converter still busy after an abort), wait.
- START: CNT<=CNT+1. If eoc=0: soc<=0, ->WAIT.
- WAIT: CNT<=CNT+1. If eoc=1: x_out<=x, err_out<=0, eoc_out[grant]<=1, ->DELIVER.
- Timeout: in START or WAIT, if CNT==TIMEOUT-1 on an edge where the normal exit condition is false:
  - soc<=0, x_out<=8'hFF, err_out<=1, eoc_out[grant]<=1, ->DELIVER.
  - Result: a dead converter sees soc high for exactly TIMEOUT cycles.
  - The normal exit condition has priority over timeout on the same edge.
- DELIVER: when soc_in[grant]=0: eoc_out<=0, LAST<=grant, busy<=0, ->IDLE.
  - err_out and x_out hold their values until the next capture.
  - A requester that dropped soc_in early (protocol violation) still gets a 1-cycle eoc_out pulse.
- Minimum latency: soc_in[k] rises before edge n, converter responds immediately:
  - soc=1 after edge n.
  - eoc_out[k]=1 after edge n+2 (one edge in START, one in WAIT).
- Requests arriving while busy are held pending and not lost (level-sensitive). No requester is served twice while another is pending.
- Exactly one eoc_out bit at most is ever 1. Only the granted bit is ever driven.
- New requests are not granted in the cycle DELIVER exits; they are granted at the next IDLE edge at the earliest.

Test Plan:
- Single request: soc_in=4'b0100, converter drops eoc 1 cycle after soc and returns x=8'hA5 3 cycles later -> grant=2, eoc_out=4'b0100, x_out=8'hA5, err_out=0. Lowering soc_in clears eoc_out next edge and busy=0.
- All four requesting continuously from reset, converter returns x=8'h10+k -> service order 0,1,2,3,0. Each requester k receives 8'h10+k; eoc_out is never multi-hot.
- Fairness: after serving 2, soc_in=4'b0101 -> requester 0 is served before 2 (scan order 3,0,1,2).
- Timeout, TIMEOUT=8: converter holds eoc=1 forever -> soc high exactly 8 cycles, then eoc_out[grant]=1, x_out=8'hFF, err_out=1. The next grant waits until eoc=1.
- Timeout in WAIT: converter drops eoc and never raises it -> abort after 8 total cycles with err_out=1. IDLE then blocks new grants until eoc returns to 1.
- Reset mid-WAIT: reset_=0 -> soc, eoc_out, busy go to 0 immediately. After release, requester 0 wins when all four request.
